control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired Mini-SRC control unit that sits directly upstream of `Datapath` and drives every control input the testbenches currently toggle by hand. It steps through a three-step instruction fetch, decodes `IR[31:27]`, and emits the per-step control word for each instruction class. It stops on `halt`, or at an instruction boundary when `Stop` is asserted.

## Interface
- No parameters; the opcode map is fixed. ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Clock  in  1  system clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents from `Datapath`
- CON_FF  in  1  branch condition flip-flop from `Datapath`
- Stop  in  1  halt request, sampled only at instruction boundaries
- Step  in  1  single-step advance pulse (present only with `CU_STEP_EN`)
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin  out  1 each  datapath register strobes
- Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout  out  1 each  ALU-side register strobes
- GRA, GRB, GRC, Rin, Rout, BAout, Cout, R15in  out  1 each  register-select and bus strobes
- CONin, InportOut, OutportIn, Read, Write  out  1 each  condition, I/O and memory strobes
- opcode  out  5  ALU operation code to `Datapath`
- Run  out  1  high while the sequencer is executing

## Operation
- States: RESET, T0–T7, HALT. Each T state lasts exactly one clock. All outputs are a registered function of the next state.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Execute steps (the last listed step returns to T0):
  - ld: T3 GRB BAout Yin; T4 Cout Zin opcode=00011; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout GRA Rin.
  - ldi: T3–T4 as ld; T5 Zlowout GRA Rin.
  - st: T3–T5 as ld; T6 GRA Rout MDRin; T7 Write.
  - add through or (register form): T3 GRB Rout Yin; T4 GRC Rout Zin opcode=IR[31:27]; T5 Zlowout GRA Rin.
  - addi/andi/ori: T3 GRB Rout Yin; T4 Cout Zin with opcode mapped to 00011/01010/01011; T5 Zlowout GRA Rin.
  - mul/div: T3 GRA Rout Yin; T4 GRB Rout Zin opcode=IR[31:27]; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 GRB Rout Zin opcode=IR[31:27]; T4 Zlowout GRA Rin.
  - br: T3 GRA Rout CONin; T4 PCout Yin; T5 Cout Zin opcode=00011; T6 Zlowout, with PCin = CON_FF.
  - jr: T3 GRA Rout PCin.
  - jal: T3 PCout R15in; T4 GRA Rout PCin.
  - in: T3 InportOut GRA Rin.
  - out: T3 GRA Rout OutportIn.
  - mfhi: T3 HIout GRA Rin.
  - mflo: T3 LOout GRA Rin.
  - nop and unassigned opcodes 11100–11111: return to T0 after T2.
  - halt: T2 → HALT.
- `opcode` output is 00000 in every step not listed above.
- HALT: all strobes are 0 and Run=0. HALT is left only via clear_n.

## Timing
- Async reset: while clear_n=0, state=RESET and every output is 0, including Run and opcode.
- First rising edge after clear_n deasserts: RESET→T0, Run=1.
- Control strobes are valid for the full cycle of their step and change only on rising edges.
- Instruction latency is fetch (3 clocks) plus execute:
  - ld/st: 8 clocks total.
  - ldi and ALU forms: 6 clocks.
  - mul/div and br: 7 clocks.
  - neg/not and jal: 5 clocks.
  - jr, in, out, mfhi, mflo: 4 clocks.
  - nop: 3 clocks.
- Stop is sampled on the edge that would enter T0. If Stop=1, the sequencer enters HALT instead, so the in-flight instruction always completes.
- A halt opcode decoded in the same cycle that Stop is asserted enters HALT once; there is no double effect.
- clear_n asserted mid-instruction aborts immediately to RESET with all strobes 0. No partial write is retried.
- CON_FF is sampled in T5 to form the registered PCin for T6.

## Configuration
- `CU_STEP_EN` defined:
  - Adds the `Step` port and a WAIT state entered instead of T0 at each instruction boundary. WAIT drives all strobes 0 and holds Run=1.
  - One `Step`=1 cycle moves WAIT→T0. Stop takes precedence over Step in WAIT.
- `CU_STEP_EN` undefined: no `Step` port, no WAIT state; instructions issue back to back.

## Test plan
- Reset: hold clear_n=0 for 3 clocks → all outputs 0. Release → next edge is T0 with PCout=MARin=IncPC=Zin=1 and Run=1.
- ldi, IR=32'h08100038: T3 GRB=BAout=Yin=1; T4 Cout=Zin=1 with opcode=00011; T5 Zlowout=GRA=Rin=1; next edge returns to T0 (6 clocks total).
- st, IR=32'h10000095: Write=1 only in T7 and MDRin=1 only in T1 and T6; 8 clocks total.
- br with CON_FF=0 then CON_FF=1: PCin=0 in T6 in the first case and PCin=1 in T6 in the second; Zlowout=1 in T6 in both.
- mul, IR=32'h78800000: LOin=1 in T5 and HIin=1 in T6, opcode=01111 in T4. Assert Stop during T4 → after T6 the state is HALT, Run=0, and all strobes stay 0 for 10 clocks.
- halt, IR=32'hD8000000: HALT entered after T2. Pull clear_n low mid-HALT → outputs remain 0; the sequencer restarts at T0 after release.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired Mini-SRC sequencer and the datapath.
// Optional feature macro: CU_STEP_EN (adds the Step single-step input).
interface control_sequencer_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        Stop;
`ifdef CU_STEP_EN
    logic        Step;
`endif
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout;
    logic        GRA, GRB, GRC, Rin, Rout, BAout, Cout, R15in;
    logic        CONin, InportOut, OutportIn, Read, Write;
    logic [4:0]  opcode;
    logic        Run;

    // Sequencer side: consumes IR/condition/requests, drives every strobe.
    modport master (
        input  IR, CON_FF, Stop,
`ifdef CU_STEP_EN
        input  Step,
`endif
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout,
        output GRA, GRB, GRC, Rin, Rout, BAout, Cout, R15in,
        output CONin, InportOut, OutportIn, Read, Write,
        output opcode, Run
    );

    // Datapath side.
    modport slave (
        output IR, CON_FF, Stop,
`ifdef CU_STEP_EN
        output Step,
`endif
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout,
        input  GRA, GRB, GRC, Rin, Rout, BAout, Cout, R15in,
        input  CONin, InportOut, OutportIn, Read, Write,
        input  opcode, Run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Mini-SRC control unit: 3-step fetch, decode of IR[31:27], then
// per-class execute steps. Every output is registered from the next state.
// Optional feature macro: CU_STEP_EN (WAIT state at instruction boundaries,
// advanced by a one-cycle Step pulse).
module control_sequencer (
    input  logic                       Clock,
    input  logic                       clear_n,
    control_sequencer_if.master        bus
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_STEP_EN
        , S_WAIT
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

    typedef struct packed {
        logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
        logic Yin, Zin, Zlowout, Zhighout, LOin, HIin, LOout, HIout;
        logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, R15in;
        logic CONin, InportOut, OutportIn, Read, Write;
        logic [4:0] opcode;
        logic Run;
    } ctrl_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;

    state_t     state_reg, state_next, last_step, boundary;
    cls_t       cls;
    ctrl_t      ctrl_reg, ctrl_next;
    logic [4:0] op, imm_op;
    logic       unused_ir_bits;

    assign op             = bus.IR[31:27];
    assign unused_ir_bits = ^bus.IR[26:0];
    assign imm_op         = (op == 5'b01100) ? OP_ADD : (op == 5'b01101) ? OP_AND : OP_OR;

    // Instruction class and the final execute step of that class.
    always_comb begin
        cls = C_NOP;
        case (op)
            5'd0:                                   cls = C_LD;
            5'd1:                                   cls = C_LDI;
            5'd2:                                   cls = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd9, 5'd10, 5'd11:               cls = C_ALU;
            5'd12, 5'd13, 5'd14:                    cls = C_IMM;
            5'd15, 5'd16:                           cls = C_MULDIV;
            5'd17, 5'd18:                           cls = C_NEGNOT;
            5'd19:                                  cls = C_BR;
            5'd20:                                  cls = C_JR;
            5'd21:                                  cls = C_JAL;
            5'd22:                                  cls = C_IN;
            5'd23:                                  cls = C_OUT;
            5'd24:                                  cls = C_MFHI;
            5'd25:                                  cls = C_MFLO;
            5'd27:                                  cls = C_HALT;
            default:                                cls = C_NOP;
        endcase
        last_step = S_T2;
        case (cls)
            C_LD, C_ST:                             last_step = S_T7;
            C_LDI, C_ALU, C_IMM:                    last_step = S_T5;
            C_MULDIV, C_BR:                         last_step = S_T6;
            C_NEGNOT, C_JAL:                        last_step = S_T4;
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO:      last_step = S_T3;
            default:                                last_step = S_T2;
        endcase
    end

    // Next-state: step through T states; Stop diverts the boundary to HALT.
    always_comb begin
`ifdef CU_STEP_EN
        boundary = bus.Stop ? S_HALT : S_WAIT;
`else
        boundary = bus.Stop ? S_HALT : S_T0;
`endif
        state_next = state_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = (cls == C_HALT) ? S_HALT :
                                   (last_step == S_T2) ? boundary : S_T3;
            S_T3:    state_next = (last_step == S_T3) ? boundary : S_T4;
            S_T4:    state_next = (last_step == S_T4) ? boundary : S_T5;
            S_T5:    state_next = (last_step == S_T5) ? boundary : S_T6;
            S_T6:    state_next = (last_step == S_T6) ? boundary : S_T7;
            S_T7:    state_next = boundary;
            S_HALT:  state_next = S_HALT;
`ifdef CU_STEP_EN
            S_WAIT:  state_next = bus.Stop ? S_HALT : (bus.Step ? S_T0 : S_WAIT);
`endif
            default: state_next = S_RESET;
        endcase
    end

    // Control word for the step about to be entered.
    always_comb begin
        ctrl_next = '0;
        ctrl_next.Run = (state_next != S_RESET) && (state_next != S_HALT);
        case (state_next)
            S_T0: begin ctrl_next.PCout = 1'b1; ctrl_next.MARin = 1'b1; ctrl_next.IncPC = 1'b1; ctrl_next.Zin = 1'b1; end
            S_T1: begin ctrl_next.Zlowout = 1'b1; ctrl_next.PCin = 1'b1; ctrl_next.Read = 1'b1; ctrl_next.MDRin = 1'b1; end
            S_T2: begin ctrl_next.MDRout = 1'b1; ctrl_next.IRin = 1'b1; end
            S_T3: case (cls)
                C_LD, C_LDI, C_ST: begin ctrl_next.GRB = 1'b1; ctrl_next.BAout = 1'b1; ctrl_next.Yin = 1'b1; end
                C_ALU, C_IMM:      begin ctrl_next.GRB = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.Yin = 1'b1; end
                C_MULDIV:          begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.Yin = 1'b1; end
                C_NEGNOT:          begin ctrl_next.GRB = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = op; end
                C_BR:              begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.CONin = 1'b1; end
                C_JR:              begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.PCin = 1'b1; end
                C_JAL:             begin ctrl_next.PCout = 1'b1; ctrl_next.R15in = 1'b1; end
                C_IN:              begin ctrl_next.InportOut = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                C_OUT:             begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.OutportIn = 1'b1; end
                C_MFHI:            begin ctrl_next.HIout = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                C_MFLO:            begin ctrl_next.LOout = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                C_LD, C_LDI, C_ST: begin ctrl_next.Cout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = OP_ADD; end
                C_ALU:             begin ctrl_next.GRC = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = op; end
                C_IMM:             begin ctrl_next.Cout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = imm_op; end
                C_MULDIV:          begin ctrl_next.GRB = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = op; end
                C_NEGNOT:          begin ctrl_next.Zlowout = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                C_BR:              begin ctrl_next.PCout = 1'b1; ctrl_next.Yin = 1'b1; end
                C_JAL:             begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.PCin = 1'b1; end
                default: ;
            endcase
            S_T5: case (cls)
                C_LD, C_ST:           begin ctrl_next.Zlowout = 1'b1; ctrl_next.MARin = 1'b1; end
                C_LDI, C_ALU, C_IMM:  begin ctrl_next.Zlowout = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                C_MULDIV:             begin ctrl_next.Zlowout = 1'b1; ctrl_next.LOin = 1'b1; end
                C_BR:                 begin ctrl_next.Cout = 1'b1; ctrl_next.Zin = 1'b1; ctrl_next.opcode = OP_ADD; end
                default: ;
            endcase
            S_T6: case (cls)
                C_LD:     begin ctrl_next.Read = 1'b1; ctrl_next.MDRin = 1'b1; end
                C_ST:     begin ctrl_next.GRA = 1'b1; ctrl_next.Rout = 1'b1; ctrl_next.MDRin = 1'b1; end
                C_MULDIV: begin ctrl_next.Zhighout = 1'b1; ctrl_next.HIin = 1'b1; end
                // Branch target is taken only when the condition flop is set.
                C_BR:     begin ctrl_next.Zlowout = 1'b1; ctrl_next.PCin = bus.CON_FF; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD:     begin ctrl_next.MDRout = 1'b1; ctrl_next.GRA = 1'b1; ctrl_next.Rin = 1'b1; end
                C_ST:     ctrl_next.Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    // State and registered control word; clear_n forces everything to zero.
    always_ff @(posedge Clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= S_RESET;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
        end
    end

    assign bus.PCout     = ctrl_reg.PCout;
    assign bus.PCin      = ctrl_reg.PCin;
    assign bus.IncPC     = ctrl_reg.IncPC;
    assign bus.MARin     = ctrl_reg.MARin;
    assign bus.MDRin     = ctrl_reg.MDRin;
    assign bus.MDRout    = ctrl_reg.MDRout;
    assign bus.IRin      = ctrl_reg.IRin;
    assign bus.Yin       = ctrl_reg.Yin;
    assign bus.Zin       = ctrl_reg.Zin;
    assign bus.Zlowout   = ctrl_reg.Zlowout;
    assign bus.Zhighout  = ctrl_reg.Zhighout;
    assign bus.LOin      = ctrl_reg.LOin;
    assign bus.HIin      = ctrl_reg.HIin;
    assign bus.LOout     = ctrl_reg.LOout;
    assign bus.HIout     = ctrl_reg.HIout;
    assign bus.GRA       = ctrl_reg.GRA;
    assign bus.GRB       = ctrl_reg.GRB;
    assign bus.GRC       = ctrl_reg.GRC;
    assign bus.Rin       = ctrl_reg.Rin;
    assign bus.Rout      = ctrl_reg.Rout;
    assign bus.BAout     = ctrl_reg.BAout;
    assign bus.Cout      = ctrl_reg.Cout;
    assign bus.R15in     = ctrl_reg.R15in;
    assign bus.CONin     = ctrl_reg.CONin;
    assign bus.InportOut = ctrl_reg.InportOut;
    assign bus.OutportIn = ctrl_reg.OutportIn;
    assign bus.Read      = ctrl_reg.Read;
    assign bus.Write     = ctrl_reg.Write;
    assign bus.opcode    = ctrl_reg.opcode;
    assign bus.Run       = ctrl_reg.Run;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer (default build, no
// single-step feature). Each instruction's expected control words are built
// from per-opcode step lists and compared on the falling clock edge.
module tb_control_sequencer;
    logic Clock = 1'b0;
    logic clear_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    control_sequencer_if sif();

    control_sequencer dut (
        .Clock   (Clock),
        .clear_n (clear_n),
        .bus     (sif.master)
    );

    always #5 Clock = ~Clock;

    // Strobe masks, MSB first in the same order obs() packs them.
    localparam logic [27:0] M_PCOUT   = 28'd1 << 27, M_PCIN     = 28'd1 << 26;
    localparam logic [27:0] M_INCPC   = 28'd1 << 25, M_MARIN    = 28'd1 << 24;
    localparam logic [27:0] M_MDRIN   = 28'd1 << 23, M_MDROUT   = 28'd1 << 22;
    localparam logic [27:0] M_IRIN    = 28'd1 << 21, M_YIN      = 28'd1 << 20;
    localparam logic [27:0] M_ZIN     = 28'd1 << 19, M_ZLOWOUT  = 28'd1 << 18;
    localparam logic [27:0] M_ZHIGH   = 28'd1 << 17, M_LOIN     = 28'd1 << 16;
    localparam logic [27:0] M_HIIN    = 28'd1 << 15, M_LOOUT    = 28'd1 << 14;
    localparam logic [27:0] M_HIOUT   = 28'd1 << 13, M_GRA      = 28'd1 << 12;
    localparam logic [27:0] M_GRB     = 28'd1 << 11, M_GRC      = 28'd1 << 10;
    localparam logic [27:0] M_RIN     = 28'd1 << 9,  M_ROUT     = 28'd1 << 8;
    localparam logic [27:0] M_BAOUT   = 28'd1 << 7,  M_COUT     = 28'd1 << 6;
    localparam logic [27:0] M_R15IN   = 28'd1 << 5,  M_CONIN    = 28'd1 << 4;
    localparam logic [27:0] M_INPORT  = 28'd1 << 3,  M_OUTPORT  = 28'd1 << 2;
    localparam logic [27:0] M_READ    = 28'd1 << 1,  M_WRITE    = 28'd1 << 0;
    localparam logic [33:0] ALL_ZERO  = 34'd0;

    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] obs();
        return {sif.PCout, sif.PCin, sif.IncPC, sif.MARin, sif.MDRin, sif.MDRout, sif.IRin,
                sif.Yin, sif.Zin, sif.Zlowout, sif.Zhighout, sif.LOin, sif.HIin, sif.LOout, sif.HIout,
                sif.GRA, sif.GRB, sif.GRC, sif.Rin, sif.Rout, sif.BAout, sif.Cout, sif.R15in,
                sif.CONin, sif.InportOut, sif.OutportIn, sif.Read, sif.Write, sif.opcode, sif.Run};
    endfunction

    function automatic logic [33:0] w(input logic [27:0] m, input logic [4:0] o);
        return {m, o, 1'b1};
    endfunction

    // Reference: ordered list of control words, one per clock of the instruction.
    function automatic void build(input logic [31:0] ir, input bit con);
        int op = int'(ir[31:27]);
        logic [4:0] opc = ir[31:27];
        exp_q.delete();
        exp_q.push_back(w(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0));
        exp_q.push_back(w(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0));
        exp_q.push_back(w(M_MDROUT | M_IRIN, 5'd0));
        if (op <= 2) begin
            exp_q.push_back(w(M_GRB | M_BAOUT | M_YIN, 5'd0));
            exp_q.push_back(w(M_COUT | M_ZIN, 5'd3));
            if (op == 1) exp_q.push_back(w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
            else         exp_q.push_back(w(M_ZLOWOUT | M_MARIN, 5'd0));
            if (op == 0) begin
                exp_q.push_back(w(M_READ | M_MDRIN, 5'd0));
                exp_q.push_back(w(M_MDROUT | M_GRA | M_RIN, 5'd0));
            end else if (op == 2) begin
                exp_q.push_back(w(M_GRA | M_ROUT | M_MDRIN, 5'd0));
                exp_q.push_back(w(M_WRITE, 5'd0));
            end
        end else if (op <= 14) begin
            exp_q.push_back(w(M_GRB | M_ROUT | M_YIN, 5'd0));
            if (op <= 11)      exp_q.push_back(w(M_GRC | M_ROUT | M_ZIN, opc));
            else if (op == 12) exp_q.push_back(w(M_COUT | M_ZIN, 5'd3));
            else if (op == 13) exp_q.push_back(w(M_COUT | M_ZIN, 5'd10));
            else               exp_q.push_back(w(M_COUT | M_ZIN, 5'd11));
            exp_q.push_back(w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        end else if (op <= 16) begin
            exp_q.push_back(w(M_GRA | M_ROUT | M_YIN, 5'd0));
            exp_q.push_back(w(M_GRB | M_ROUT | M_ZIN, opc));
            exp_q.push_back(w(M_ZLOWOUT | M_LOIN, 5'd0));
            exp_q.push_back(w(M_ZHIGH | M_HIIN, 5'd0));
        end else if (op <= 18) begin
            exp_q.push_back(w(M_GRB | M_ROUT | M_ZIN, opc));
            exp_q.push_back(w(M_ZLOWOUT | M_GRA | M_RIN, 5'd0));
        end else if (op == 19) begin
            exp_q.push_back(w(M_GRA | M_ROUT | M_CONIN, 5'd0));
            exp_q.push_back(w(M_PCOUT | M_YIN, 5'd0));
            exp_q.push_back(w(M_COUT | M_ZIN, 5'd3));
            exp_q.push_back(w(M_ZLOWOUT | (con ? M_PCIN : 28'd0), 5'd0));
        end else if (op == 20) exp_q.push_back(w(M_GRA | M_ROUT | M_PCIN, 5'd0));
        else if (op == 21) begin
            exp_q.push_back(w(M_PCOUT | M_R15IN, 5'd0));
            exp_q.push_back(w(M_GRA | M_ROUT | M_PCIN, 5'd0));
        end
        else if (op == 22) exp_q.push_back(w(M_INPORT | M_GRA | M_RIN, 5'd0));
        else if (op == 23) exp_q.push_back(w(M_GRA | M_ROUT | M_OUTPORT, 5'd0));
        else if (op == 24) exp_q.push_back(w(M_HIOUT | M_GRA | M_RIN, 5'd0));
        else if (op == 25) exp_q.push_back(w(M_LOOUT | M_GRA | M_RIN, 5'd0));
    endfunction

    // Hold reset 3 clocks checking zeros, release; returns with T0 visible.
    task automatic do_reset();
        sif.Stop = 1'b0;
        clear_n  = 1'b0;
        #1 check("reset_async", obs(), ALL_ZERO);
        repeat (3) begin
            @(negedge Clock);
            check("reset_hold", obs(), ALL_ZERO);
        end
        clear_n = 1'b1;
        @(negedge Clock);
    endtask

    task automatic check_halt(input int n);
        repeat (n) begin
            check("halted", obs(), ALL_ZERO);
            @(negedge Clock);
        end
    endtask

    // Called at the falling edge where T0 of this instruction is visible.
    task automatic run_instr(input logic [31:0] ir, input bit con, input bit stop_req, input int abort_at);
        int last;
        build(ir, con);
        last = exp_q.size() - 1;
        sif.IR     = ir;
        sif.CON_FF = con;
        sif.Stop   = 1'b0;
        for (int i = 0; i <= last; i++) begin
            check($sformatf("op%0d_t%0d", ir[31:27], i), obs(), exp_q[i]);
            if (i == abort_at) begin
                clear_n = 1'b0;
                #1 check("abort", obs(), ALL_ZERO);
                @(negedge Clock);
                check("abort_hold", obs(), ALL_ZERO);
                clear_n = 1'b1;
                @(negedge Clock);
                return;
            end
            if (stop_req && (i >= 4 || i == last)) sif.Stop = 1'b1;
            @(negedge Clock);
        end
    endtask

    initial begin
        logic [31:0] ir;
        bit stop_req;
        int abort_at;
        sif.IR = 32'd0;
        sif.CON_FF = 1'b0;
        sif.Stop = 1'b0;
        #2 do_reset();

        run_instr(32'h08100038, 1'b0, 1'b0, -1);
        run_instr(32'h10000095, 1'b0, 1'b0, -1);
        run_instr({5'b10011, 27'h0123456}, 1'b0, 1'b0, -1);
        run_instr({5'b10011, 27'h0654321}, 1'b1, 1'b0, -1);
        run_instr(32'h78800000, 1'b0, 1'b1, -1);
        check_halt(10);
        do_reset();
        run_instr(32'hD8000000, 1'b0, 1'b0, -1);
        check_halt(3);
        do_reset();
        run_instr(32'hD8000000, 1'b0, 1'b1, -1);
        check_halt(3);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            ir = $urandom;
            if (ir[31:27] == 5'd27 && $urandom_range(0, 3) != 0) ir[31:27] = 5'd26;
            stop_req = ($urandom_range(0, 24) == 0);
            abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
            build(ir, 1'b0);
            if (abort_at >= exp_q.size()) abort_at = -1;
            run_instr(ir, 1'($urandom_range(0, 1)), stop_req, abort_at);
            if (abort_at < 0 && (stop_req || ir[31:27] == 5'd27)) begin
                check_halt(2);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
